// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display monitor: segment bit positions,
// the hex glyph table and the capture FSM state encoding.
`timescale 1ns/1ps
package seven_segment_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high g..a patterns; entry i is the glyph for hex digit i.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLING = 2'd1,
        CAPTURED = 2'd2
    } state_t;

    function automatic logic is_one_hot(input logic [7:0] vec, input int width);
        logic [7:0] masked;
        masked = vec & ((8'd1 << width) - 8'd1);
        return (masked != 8'd0) && ((masked & (masked - 8'd1)) == 8'd0);
    endfunction

endpackage

// File: rtl/segment_glyph_decoder.sv
// Combinational reverse lookup of a 7-segment pattern into its hex nibble;
// glyphValid is low for any pattern that is not one of the 16 hex glyphs.
`timescale 1ns/1ps
module segment_glyph_decoder
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       glyphValid
);

    // Table entries are distinct, so OR-accumulating the single match is exact.
    always_comb begin
        nibble     = 4'h0;
        glyphValid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            nibble     = nibble | ({4{pattern == GLYPH_TABLE[i]}} & 4'(i));
            glyphValid = glyphValid | (pattern == GLYPH_TABLE[i]);
        end
    end

endmodule

// File: rtl/seven_segment_decoder.sv
// Monitor for a multiplexed 7-segment display: reconstructs per-digit nibbles/dp and
// flags bad glyphs and digit collisions. Define SEVEN_SEGMENT_DECODER_SYNC_EN to add
// a two-flop input synchronizer (two extra cycles of latency).
`timescale 1ns/1ps
module seven_segment_decoder
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [7:0]              segmentEnableN,
    input  logic [NUM_DIGITS-1:0]   digitEnableN,
    output logic [4*NUM_DIGITS-1:0] data,
    output logic [NUM_DIGITS-1:0]   pointEnable,
    output logic [NUM_DIGITS-1:0]   digitValid,
    output logic [NUM_DIGITS-1:0]   badPattern,
    output logic                    collision,
    output logic                    frameDone
);

    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_LIM = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    logic [SW-1:0]           raw_s;
    logic [SW-1:0]           sample_r;
    logic [SW-1:0]           last_r;
    logic [NUM_DIGITS-1:0]   digit_sel_s;
    logic [6:0]              pattern_s;
    logic                    dp_s;
    logic                    one_hot_s;
    logic                    multi_s;
    logic                    changed_s;
    logic                    restart_capture_s;
    logic                    capture_s;
    logic [3:0]              nibble_s;
    logic                    glyph_valid_s;
    state_t                  state_r;
    logic [CW-1:0]           settle_cnt_r;
    logic [4*NUM_DIGITS-1:0] data_r;
    logic [NUM_DIGITS-1:0]   point_r;
    logic [NUM_DIGITS-1:0]   valid_r;
    logic [NUM_DIGITS-1:0]   bad_r;
    logic [NUM_DIGITS-1:0]   frame_seen_r;
    logic                    collision_r;
    logic                    frame_done_r;

`ifdef SEVEN_SEGMENT_DECODER_SYNC_EN
    logic [SW-1:0] sync1_r;
    logic [SW-1:0] sync2_r;

    // Two-flop synchronizer for inputs arriving from pins or another clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= {SW{1'b0}};
            sync2_r <= {SW{1'b0}};
        end else begin
            sync1_r <= {~digitEnableN, ~segmentEnableN};
            sync2_r <= sync1_r;
        end
    end

    assign raw_s = sync2_r;
`else
    assign raw_s = {~digitEnableN, ~segmentEnableN};
`endif

    // Sample register plus a one-cycle-old copy used for stability comparison.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_r <= {SW{1'b0}};
            last_r   <= {SW{1'b0}};
        end else begin
            sample_r <= raw_s;
            last_r   <= sample_r;
        end
    end

    assign digit_sel_s = sample_r[SW-1:8];
    assign pattern_s   = sample_r[SEG_G:SEG_A];
    assign dp_s        = sample_r[SEG_DP];
    assign multi_s     = (digit_sel_s & (digit_sel_s - NUM_DIGITS'(1))) != {NUM_DIGITS{1'b0}};
    assign one_hot_s   = (digit_sel_s != {NUM_DIGITS{1'b0}}) && !multi_s;
    assign changed_s   = sample_r != last_r;
    // With a one-sample settle requirement, a fresh one-hot sample captures immediately.
    assign restart_capture_s = one_hot_s && (SETTLE_LIM == CNT_ONE);

    segment_glyph_decoder u_glyph (
        .pattern    (pattern_s),
        .nibble     (nibble_s),
        .glyphValid (glyph_valid_s)
    );

    // Capture strobe: fires once per dwell when the settle count is reached.
    always_comb begin
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                capture_s = restart_capture_s;
            end
            SETTLING: begin
                if (changed_s) begin
                    capture_s = restart_capture_s;
                end else begin
                    capture_s = (settle_cnt_r == (SETTLE_LIM - CNT_ONE));
                end
            end
            CAPTURED: begin
                capture_s = changed_s && restart_capture_s;
            end
            default: begin
                capture_s = 1'b0;
            end
        endcase
    end

    // Dwell-tracking FSM with saturating settle counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            settle_cnt_r <= CNT_ZERO;
        end else if ((state_r == IDLE) || changed_s) begin
            if (one_hot_s) begin
                settle_cnt_r <= CNT_ONE;
                state_r      <= capture_s ? CAPTURED : SETTLING;
            end else begin
                settle_cnt_r <= CNT_ZERO;
                state_r      <= IDLE;
            end
        end else begin
            case (state_r)
                SETTLING: begin
                    state_r <= capture_s ? CAPTURED : SETTLING;
                    if (settle_cnt_r < SETTLE_LIM) begin
                        settle_cnt_r <= settle_cnt_r + CNT_ONE;
                    end else begin
                        settle_cnt_r <= settle_cnt_r;
                    end
                end
                CAPTURED: begin
                    state_r      <= CAPTURED;
                    settle_cnt_r <= settle_cnt_r;
                end
                default: begin
                    state_r      <= IDLE;
                    settle_cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    // Sticky collision flag; any multi-hot sample is a select collision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            collision_r <= 1'b0;
        end else begin
            collision_r <= collision_r | multi_s;
        end
    end

    // Per-digit capture: an invalid glyph keeps the old nibble but flags the digit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_r  <= {(4*NUM_DIGITS){1'b0}};
            point_r <= {NUM_DIGITS{1'b0}};
            valid_r <= {NUM_DIGITS{1'b0}};
            bad_r   <= {NUM_DIGITS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (capture_s && digit_sel_s[i]) begin
                    if (glyph_valid_s) begin
                        data_r[4*i +: 4] <= nibble_s;
                        bad_r[i]         <= 1'b0;
                    end else begin
                        bad_r[i]         <= 1'b1;
                    end
                    point_r[i] <= dp_s;
                    valid_r[i] <= 1'b1;
                end
            end
        end
    end

    // Frame tracking: a capture on the clearing edge seeds the next frame's mask.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_seen_r <= {NUM_DIGITS{1'b0}};
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= &frame_seen_r;
            frame_seen_r <= ((&frame_seen_r) ? {NUM_DIGITS{1'b0}} : frame_seen_r)
                          | (capture_s ? digit_sel_s : {NUM_DIGITS{1'b0}});
        end
    end

    assign data        = data_r;
    assign pointEnable = point_r;
    assign digitValid  = valid_r;
    assign badPattern  = bad_r;
    assign collision   = collision_r;
    assign frameDone   = frame_done_r;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench for seven_segment_decoder: each dwell pushes cycle-stamped expected
// output snapshots, which a monitor pops and compares as the cycles arrive.
`timescale 1ns/1ps
module tb_seven_segment_decoder;

    localparam int S = 4;
`ifdef SEVEN_SEGMENT_DECODER_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    localparam logic [15:0][6:0] GLYPHS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  segmentEnableN;
    logic [3:0]  digitEnableN;
    logic [15:0] data;
    logic [3:0]  pointEnable;
    logic [3:0]  digitValid;
    logic [3:0]  badPattern;
    logic        collision;
    logic        frameDone;

    seven_segment_decoder #(.NUM_DIGITS(4), .SETTLE_CYCLES(S)) dut (
        .clock          (clock),
        .reset          (reset),
        .segmentEnableN (segmentEnableN),
        .digitEnableN   (digitEnableN),
        .data           (data),
        .pointEnable    (pointEnable),
        .digitValid     (digitValid),
        .badPattern     (badPattern),
        .collision      (collision),
        .frameDone      (frameDone)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] cyc;
        logic [63:0] tag;
        logic [31:0] exp;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int          cyc = 0;
    int          check_count = 0;
    int          error_count = 0;

    logic [15:0] m_data;
    logic [3:0]  m_point, m_valid, m_bad, m_mask;
    logic        m_col;
    int          pulse_cyc;

    function automatic logic [31:0] observed();
        return {2'b00, frameDone, collision, badPattern, digitValid, pointEnable, data};
    endfunction

    function automatic logic [31:0] expect_at(input int t);
        return {2'b00, (t == pulse_cyc), m_col, m_bad, m_valid, m_point, m_data};
    endfunction

    task automatic check_value(input logic [63:0] tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [63:0] tag, input int t);
        sb_entry_t e;
        e.cyc = 32'(t);
        e.tag = tag;
        e.exp = expect_at(t);
        sb_q.push_back(e);
    endtask

    task automatic model_reset();
        m_data = 16'h0000; m_point = 4'h0; m_valid = 4'h0; m_bad = 4'h0;
        m_mask = 4'h0; m_col = 1'b0; pulse_cyc = -1;
    endtask

    // Called at a negedge: drive one dwell and schedule its expected snapshots.
    task automatic dwell(input logic [3:0] den_n, input logic [7:0] seg_n, input int len,
                         input logic [63:0] tag);
        logic [3:0] sel;
        logic [6:0] pat;
        logic       hit;
        logic [3:0] nib;
        int         c;
        int         cc;
        digitEnableN   = den_n;
        segmentEnableN = seg_n;
        c   = cyc;
        sel = ~den_n;
        pat = ~seg_n[6:0];
        if ((sel & (sel - 4'd1)) != 4'd0) m_col = 1'b1;
        if ((sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0) && (len >= S)) begin
            cc = c + S + 1 + EXTRA;
            push_exp(tag, cc - 1);
            hit = 1'b0;
            nib = 4'h0;
            for (int k = 0; k < 16; k++) begin
                if (GLYPHS[k] == pat) begin
                    hit = 1'b1;
                    nib = 4'(k);
                end
            end
            for (int d = 0; d < 4; d++) begin
                if (sel[d]) begin
                    if (hit) m_data[4*d +: 4] = nib;
                    m_bad[d]   = !hit;
                    m_point[d] = ~seg_n[7];
                    m_valid[d] = 1'b1;
                    m_mask[d]  = 1'b1;
                end
            end
            push_exp(tag, cc);
            if (m_mask == 4'hF) begin
                pulse_cyc = cc + 1;
                m_mask    = 4'h0;
                push_exp(tag, cc + 1);
            end
        end
        push_exp(tag, c + len + 1 + EXTRA);
        repeat (len) @(negedge clock);
    endtask

    task automatic drain(input logic [63:0] tag);
        int guard;
        guard = 0;
        while ((sb_q.size() != 0) && (guard < 200)) begin
            @(negedge clock);
            guard++;
        end
        check_value(tag, 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: count posedges and compare due scoreboard entries just after each edge.
    initial begin
        sb_entry_t e;
        forever begin
            @(posedge clock);
            cyc = cyc + 1;
            #1;
            while ((sb_q.size() != 0) && (sb_q[0].cyc == 32'(cyc))) begin
                e = sb_q.pop_front();
                check_value(e.tag, observed(), e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset          = 1'b1;
        digitEnableN   = 4'hF;
        segmentEnableN = 8'hFF;
        model_reset();
        repeat (2) @(negedge clock);
        check_value("rst", observed(), 32'h0);
        reset = 1'b0;

        // Scan 1,2,3,4 across digits 0..3.
        dwell(4'b1110, 8'hF9, 8, "scan0");
        dwell(4'b1101, 8'hA4, 8, "scan1");
        dwell(4'b1011, 8'hB0, 8, "scan2");
        dwell(4'b0111, 8'h99, 8, "scan3");
        // Digit 2: 8 with dp, then 8 without dp.
        dwell(4'b1011, 8'h00, 6, "dp_on");
        dwell(4'b1011, 8'h80, 6, "dp_off");
        // Short dwell on digit 1 must not capture.
        dwell(4'b1101, 8'hC0, 3, "short");
        dwell(4'b1111, 8'hFF, 4, "gap");
        // Single-cycle collision, then a normal dwell still captures.
        dwell(4'b1100, 8'hC0, 1, "coll");
        dwell(4'b1110, 8'h99, 6, "after_c");
        // Digit 0: 5, invalid 0x01, then 1.
        dwell(4'b1110, 8'h92, 6, "five");
        dwell(4'b1110, 8'hFE, 6, "badpat");
        dwell(4'b1110, 8'hF9, 6, "goodpat");
        // Blank digit 1, then digit 3 completes a second frame.
        dwell(4'b1101, 8'hFF, 6, "blank");
        dwell(4'b0111, 8'hF8, 6, "frame2");
        dwell(4'b1111, 8'hFF, 3, "gap2");
        drain("drain1");

        // Reset in the middle of a digit 3 settling window.
        digitEnableN   = 4'b0111;
        segmentEnableN = 8'h86;
        repeat (2 + EXTRA) @(negedge clock);
        reset = 1'b1;
        #1;
        check_value("rst_mid", observed(), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        dwell(4'b0111, 8'h86, 8, "rcap");
        dwell(4'b1111, 8'hFF, 3, "gap3");
        drain("drain2");

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
- Receive-side counterpart of the multiplexed seven-segment driver.
- Watches the active-low segment and digit-enable lines of a multiplexed display and reconstructs the per-digit hex nibbles and decimal points being shown.
- Used as a loopback checker on the board and as a display monitor in benches; reports malformed patterns and digit-select collisions.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits observed; range 1..8.
- SETTLE_CYCLES, 4: consecutive identical samples required before a digit is captured; minimum 1.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- segmentEnableN  input  8  active-low segments; bit0=a … bit6=g, bit7=dp.
- digitEnableN  input  NUM_DIGITS  active-low digit selects; bit i is digit i.
- data  output  4*NUM_DIGITS  decoded nibbles; digit i occupies bits [4i+3:4i].
- pointEnable  output  NUM_DIGITS  captured dp state per digit, active-high.
- digitValid  output  NUM_DIGITS  digit captured at least once since reset.
- badPattern  output  NUM_DIGITS  sticky; last settled pattern on digit i was not a hex glyph.
- collision  output  1  sticky; more than one digit was enabled at once.
- frameDone  output  1  one-cycle pulse when every digit has been captured since the previous pulse.

Behaviour:
- Reset values: all outputs 0; internal state IDLE; settle counter 0; frame-seen mask 0.
- Sample = {one-hot digit index, segment pattern} from the inverted inputs, registered each cycle.
- Glyph table (segments active-high, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - dp is decoded independently of the glyph.
- FSM:
  - IDLE: no digit enabled, or more than one digit enabled.
    - Multiple enabled: set collision and stay in IDLE.
    - Exactly one digit enabled: go to SETTLING with counter=1.
  - SETTLING: compare each sample with the previous one.
    - Identical: increment the counter.
    - Different: restart with counter=1, or go to IDLE if the new sample is not one-hot.
    - Counter reaches SETTLE_CYCLES: capture and go to CAPTURED.
  - CAPTURED: hold until the sample changes, then re-evaluate as in IDLE on that same cycle. Exactly one capture per dwell.
- Capture to digit i:
  - Valid glyph: data nibble updated, badPattern[i] cleared.
  - Invalid glyph: data nibble retained, badPattern[i] set.
  - In both cases: pointEnable[i] takes dp, digitValid[i] set, frame-seen bit i set.
- Latency: a new stable input is visible on the outputs SETTLE_CYCLES+1 clocks after it first appears at the inputs (+2 with the sync feature). With SETTLE_CYCLES=1, capture occurs on the first registered sample.
- frameDone:
  - Asserted on the cycle after the frame-seen mask becomes all-ones.
  - The mask clears on the same edge that asserts frameDone.
  - A capture coinciding with that clear is counted into the new mask.
- Blank digit (segments all off, dp off) is an invalid glyph: badPattern set, nibble retained.
- collision is cleared only by reset.
- Reset mid-dwell: returns to IDLE immediately; a still-stable input is re-captured only after a full SETTLE_CYCLES count.
- Settle counter width is clog2(SETTLE_CYCLES+1) and saturates; it never wraps.

Optional Feature:
- SEVEN_SEGMENT_DECODER_SYNC_EN
  - Defined: a two-flop synchronizer is placed on all input bits ahead of the sample register, adding 2 cycles of latency, for inputs from pins or a foreign clock.
  - Undefined: inputs feed the sample register directly.

Decomposition:
- Package seven_segment_pkg contains:
  - segment bit index constants (SEG_A..SEG_G, SEG_DP);
  - the 16-entry glyph table;
  - FSM state encoding (IDLE, SETTLING, CAPTURED).
- Sub-module segment_glyph_decoder: combinational; 7-bit pattern in, nibble plus glyphValid out; shared with future display blocks.

Test Plan:
- Scan digits 0..3 showing 1,2,3,4 with 8-cycle dwells (SETTLE_CYCLES=4) -> data=16'h4321, digitValid=4'hF, one frameDone pulse after digit 3 is captured.
- Digit 2 shows pattern 7F with dp on, then 7F with dp off, each dwell ≥4 cycles -> nibble 2=8; pointEnable[2] goes 1 then 0.
- Digit 1 pattern 3F held for only 3 cycles, then changed -> no capture; data and digitValid[1] unchanged.
- digitEnableN=4'b1100 for 1 cycle -> collision=1 and stays 1; no capture. Subsequently, a valid one-hot dwell still captures.
- Digit 0 shows invalid pattern 0x01 after showing 5 (6D) -> badPattern[0]=1, nibble 0 stays 5. A later 0x06 clears badPattern[0] and sets nibble 0=1.
- Reset asserted mid-SETTLING for digit 3 -> all outputs 0. With input held, capture reappears exactly SETTLE_CYCLES+1 cycles after reset release (+2 with SEVEN_SEGMENT_DECODER_SYNC_EN).
